// File: rtl/ht_ecore_ctrl_pkg.sv
// Shared definitions for the E-core boot/run controller.
//   ecore_state_e : FSM state encoding, also reported in STATUS[2:0]
//   Off*          : register byte offsets
//   Irq*/Ctrl*    : bit indices inside IRQ_STAT and CTRL
package ht_ecore_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StBoot  = 3'd1,
        StRun   = 3'd2,
        StDone  = 3'd3,
        StError = 3'd4
    } ecore_state_e;

    localparam int unsigned OffCtrl     = 32'h00;
    localparam int unsigned OffStatus   = 32'h04;
    localparam int unsigned OffCycles   = 32'h08;
    localparam int unsigned OffIrqStat  = 32'h0C;
    localparam int unsigned OffDoorbell = 32'h10;
    localparam int unsigned OffWdog     = 32'h14;

    localparam int unsigned IrqDone    = 0;
    localparam int unsigned IrqFault   = 1;
    localparam int unsigned IrqTimeout = 2;

    localparam int unsigned CtrlStart = 0;
    localparam int unsigned CtrlAbort = 1;
    localparam int unsigned CtrlIrqEn = 2;

endpackage

// File: rtl/ht_ecore_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and load.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (count -> 0)
//   clr           : synchronous clear to 0 (highest priority)
//   load/load_val : synchronous load
//   en            : increment, holds at all-ones
//   count         : current value
module ht_ecore_ctrl_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ht_ecore_ctrl.sv
// Boot/run controller for the E core, driven by the P core over a simple register port.
// Sequences E-core reset release, tracks run/halt/fault, counts run cycles, rings a
// doorbell IRQ into the E core and raises a completion IRQ to the P core.
// Ports:
//   clk_i, rst_ni                         : clock, async active-low reset
//   reg_req_i/we_i/addr_i/wdata_i         : register request (no stall)
//   reg_rvalid_o/rdata_o/err_o            : response, one cycle after each request
//   ecore_resetn_o, ecore_irq_o           : to E core (io_aresetn, io_irq)
//   ecore_halted_i/fault_i/wfi_i          : from E core
//   pcore_irq_o                           : completion IRQ to the P core
// Build option: define HT_ECORE_WDOG_EN to add the WDOG register (0x14) and timeout path.
module ht_ecore_ctrl
    import ht_ecore_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned BOOT_DLY = 16,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned DB_PULSE = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              reg_req_i,
    input  logic              reg_we_i,
    input  logic [ADDR_W-1:0] reg_addr_i,
    input  logic [31:0]       reg_wdata_i,
    output logic              reg_rvalid_o,
    output logic [31:0]       reg_rdata_o,
    output logic              reg_err_o,
    output logic              ecore_resetn_o,
    output logic              ecore_irq_o,
    input  logic              ecore_halted_i,
    input  logic              ecore_fault_i,
    input  logic              ecore_wfi_i,
    output logic              pcore_irq_o
);

    localparam int unsigned BOOT_W = $clog2(BOOT_DLY + 1);
    // One spare code above DB_PULSE so a saturated counter never looks active.
    localparam int unsigned DB_W   = $clog2(DB_PULSE + 2);

    ecore_state_e      state, state_next;
    logic              irq_en;
    logic [2:0]        irq_stat, irq_stat_next, irq_set, irq_clr;
    logic [31:0]       rdata_next;
    logic [ADDR_W-1:0] addr;
    logic              hit_ctrl, hit_status, hit_cycles, hit_irq, hit_db, hit_wdog, mapped;
    logic              wr_ctrl, wr_irq, wr_db, start, abort, timeout;
    logic [BOOT_W-1:0] boot_cnt;
    logic [CNT_W-1:0]  cycles;
    logic [DB_W-1:0]   db_cnt;
    logic              unused_wdata;

    assign unused_wdata = ^reg_wdata_i;

    // Register decode on word address
    assign addr       = reg_addr_i & ~ADDR_W'(3);
    assign hit_ctrl   = (addr == ADDR_W'(OffCtrl));
    assign hit_status = (addr == ADDR_W'(OffStatus));
    assign hit_cycles = (addr == ADDR_W'(OffCycles));
    assign hit_irq    = (addr == ADDR_W'(OffIrqStat));
    assign hit_db     = (addr == ADDR_W'(OffDoorbell));
`ifdef HT_ECORE_WDOG_EN
    assign hit_wdog   = (addr == ADDR_W'(OffWdog));
`else
    assign hit_wdog   = 1'b0;
`endif
    assign mapped = hit_ctrl | hit_status | hit_cycles | hit_irq | hit_db | hit_wdog;

    assign wr_ctrl = reg_req_i & reg_we_i & hit_ctrl;
    assign wr_irq  = reg_req_i & reg_we_i & hit_irq;
    assign wr_db   = reg_req_i & reg_we_i & hit_db;
    assign start   = wr_ctrl & reg_wdata_i[CtrlStart];
    assign abort   = wr_ctrl & reg_wdata_i[CtrlAbort];

`ifdef HT_ECORE_WDOG_EN
    logic [31:0] wdog;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog <= '0;
        end else if (reg_req_i && reg_we_i && hit_wdog) begin
            wdog <= reg_wdata_i;
        end
    end
    assign timeout = (state == StRun) && (wdog != '0) && (32'(cycles) >= wdog);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        irq_set    = '0;
        unique case (state)
            StIdle: if (start) state_next = StBoot;
            StBoot: if (boot_cnt == BOOT_W'(BOOT_DLY - 1)) state_next = StRun;
            StRun: begin
                // fault beats halted, both beat the watchdog
                if (ecore_fault_i) begin
                    state_next        = StError;
                    irq_set[IrqFault] = 1'b1;
                end else if (ecore_halted_i) begin
                    state_next       = StDone;
                    irq_set[IrqDone] = 1'b1;
                end else if (timeout) begin
                    state_next          = StError;
                    irq_set[IrqTimeout] = 1'b1;
                end
            end
            StDone, StError: if (start) state_next = StBoot;
            default: state_next = StIdle;
        endcase
        if (abort) state_next = StIdle;
    end

    // Set beats W1C clear in the same cycle
    assign irq_clr       = wr_irq ? reg_wdata_i[2:0] : 3'b000;
    assign irq_stat_next = (irq_stat & ~irq_clr) | irq_set;

    ht_ecore_ctrl_sat_counter #(.WIDTH(BOOT_W)) u_boot_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr      (state != StBoot),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == StBoot),
        .count    (boot_cnt)
    );

    // Counts RUN cycles that stay in RUN, so the exit cycle leaves CYCLES frozen
    ht_ecore_ctrl_sat_counter #(.WIDTH(CNT_W)) u_cycles (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr      ((state_next == StBoot) && (state != StBoot)),
        .load     (1'b0),
        .load_val ('0),
        .en       ((state == StRun) && (state_next == StRun)),
        .count    (cycles)
    );

    // Doorbell: load 1, pulse is active while the count is 1..DB_PULSE
    ht_ecore_ctrl_sat_counter #(.WIDTH(DB_W)) u_db_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr      (state != StRun),
        .load     (wr_db),
        .load_val (DB_W'(1)),
        .en       (db_cnt != '0),
        .count    (db_cnt)
    );

    assign ecore_irq_o = (state == StRun) && (db_cnt != '0) && (db_cnt <= DB_W'(DB_PULSE));
    assign ecore_resetn_o = (state == StRun) || (state == StDone) || (state == StError);

    always_comb begin
        rdata_next = '0;
        if (reg_req_i && !reg_we_i) begin
            if (hit_ctrl) rdata_next[CtrlIrqEn] = irq_en;
            if (hit_status) begin
                rdata_next[2:0] = state;
                rdata_next[3]   = ecore_halted_i;
                rdata_next[4]   = ecore_fault_i;
                rdata_next[5]   = ecore_wfi_i;
            end
            if (hit_cycles) rdata_next = 32'(cycles);
            if (hit_irq) rdata_next[2:0] = irq_stat;
`ifdef HT_ECORE_WDOG_EN
            if (hit_wdog) rdata_next = wdog;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= StIdle;
            irq_en       <= 1'b0;
            irq_stat     <= '0;
            pcore_irq_o  <= 1'b0;
            reg_rvalid_o <= 1'b0;
            reg_rdata_o  <= '0;
            reg_err_o    <= 1'b0;
        end else begin
            state        <= state_next;
            irq_stat     <= irq_stat_next;
            pcore_irq_o  <= irq_en & (|irq_stat);
            reg_rvalid_o <= reg_req_i;
            reg_rdata_o  <= rdata_next;
            reg_err_o    <= reg_req_i & ~mapped;
            if (wr_ctrl) irq_en <= reg_wdata_i[CtrlIrqEn];
        end
    end

endmodule

// File: tb/tb_ht_ecore_ctrl.sv
module tb_ht_ecore_ctrl;

    logic        clk, rst_ni;
    logic        reg_req, reg_we;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        reg_rvalid, reg_err;
    logic        ecore_resetn, ecore_irq, pcore_irq;
    logic        halted, fault, wfi;

    int passed = 0;
    int total  = 0;

    ht_ecore_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .reg_req_i      (reg_req),
        .reg_we_i       (reg_we),
        .reg_addr_i     (reg_addr),
        .reg_wdata_i    (reg_wdata),
        .reg_rvalid_o   (reg_rvalid),
        .reg_rdata_o    (reg_rdata),
        .reg_err_o      (reg_err),
        .ecore_resetn_o (ecore_resetn),
        .ecore_irq_o    (ecore_irq),
        .ecore_halted_i (halted),
        .ecore_fault_i  (fault),
        .ecore_wfi_i    (wfi),
        .pcore_irq_o    (pcore_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One register access; called at a negedge, returns at the next negedge with the response.
    task automatic bus(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output logic rv);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wd;
        @(negedge clk);
        rv = reg_rvalid;
        rd = reg_rdata;
        er = reg_err;
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
    endtask

    // START, then wait (bounded) for reset release; returns at a negedge in RUN cycle 1
    task automatic boot_to_run(output int low_cycles);
        logic [31:0] rd;
        logic er, rv;
        bus(1'b1, 8'h00, 32'h1, rd, er, rv);
        low_cycles = 0;
        while (!ecore_resetn && low_cycles < 50) begin
            low_cycles++;
            @(negedge clk);
        end
        total++;
        if (!ecore_resetn) $display("FAIL boot_timeout: resetn=%b want 1", ecore_resetn);
        else passed++;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({ecore_resetn, ecore_irq, pcore_irq, reg_rvalid, reg_err} !== 5'b0 ||
            reg_rdata !== 32'h0)
            $display("FAIL reset_outputs: got %b/%h want 00000/0",
                     {ecore_resetn, ecore_irq, pcore_irq, reg_rvalid, reg_err}, reg_rdata);
        else passed++;
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_boot();
        logic [31:0] rd;
        logic er, rv;
        int lows;
        boot_to_run(lows);
        total++;
        if (lows !== 16) $display("FAIL boot_low_cycles: got %0d want 16", lows);
        else passed++;
        bus(1'b0, 8'h04, 32'h0, rd, er, rv);
        total++;
        if (rd[2:0] !== 3'd2 || rv !== 1'b1 || er !== 1'b0)
            $display("FAIL status_run: got %0d rv=%b err=%b want 2 1 0", rd[2:0], rv, er);
        else passed++;
    endtask

    task automatic test_run_done();
        logic [31:0] rd;
        logic er, rv;
        int lows;
        bus(1'b1, 8'h00, 32'h2, rd, er, rv);
        boot_to_run(lows);
        repeat (100) @(negedge clk);
        halted = 1'b1;
        @(negedge clk);
        halted = 1'b0;
        bus(1'b0, 8'h04, 32'h0, rd, er, rv);
        total++;
        if (rd[2:0] !== 3'd3) $display("FAIL state_done: got %0d want 3", rd[2:0]);
        else passed++;
        bus(1'b0, 8'h08, 32'h0, rd, er, rv);
        total++;
        if (rd !== 32'd100) $display("FAIL cycles_done: got %0d want 100", rd);
        else passed++;
        bus(1'b0, 8'h0C, 32'h0, rd, er, rv);
        total++;
        if (rd !== 32'h1) $display("FAIL irq_stat_done: got %h want 1", rd);
        else passed++;
        total++;
        if (pcore_irq !== 1'b0) $display("FAIL pcore_irq_masked: got %b want 0", pcore_irq);
        else passed++;
        bus(1'b1, 8'h00, 32'h4, rd, er, rv);
        total++;
        if (rd !== 32'h0 || er !== 1'b0) $display("FAIL write_rdata: got %h err=%b want 0 0", rd, er);
        else passed++;
        @(negedge clk);
        total++;
        if (pcore_irq !== 1'b1) $display("FAIL pcore_irq_en: got %b want 1", pcore_irq);
        else passed++;
        bus(1'b1, 8'h0C, 32'h1, rd, er, rv);
        bus(1'b0, 8'h0C, 32'h0, rd, er, rv);
        total++;
        if (rd !== 32'h0) $display("FAIL irq_stat_w1c: got %h want 0", rd);
        else passed++;
        total++;
        if (pcore_irq !== 1'b0) $display("FAIL pcore_irq_clear: got %b want 0", pcore_irq);
        else passed++;
    endtask

    task automatic test_fault_priority();
        logic [31:0] rd;
        logic er, rv;
        int lows;
        boot_to_run(lows);
        repeat (5) @(negedge clk);
        halted = 1'b1;
        fault  = 1'b1;
        @(negedge clk);
        halted = 1'b0;
        fault  = 1'b0;
        bus(1'b0, 8'h04, 32'h0, rd, er, rv);
        total++;
        if (rd[2:0] !== 3'd4 || ecore_resetn !== 1'b1)
            $display("FAIL state_error: got %0d resetn=%b want 4 1", rd[2:0], ecore_resetn);
        else passed++;
        bus(1'b0, 8'h0C, 32'h0, rd, er, rv);
        total++;
        if (rd !== 32'h2) $display("FAIL irq_stat_fault: got %h want 2", rd);
        else passed++;
        bus(1'b1, 8'h00, 32'h3, rd, er, rv);
        bus(1'b0, 8'h04, 32'h0, rd, er, rv);
        total++;
        if (rd[2:0] !== 3'd0 || ecore_resetn !== 1'b0)
            $display("FAIL abort_idle: got %0d resetn=%b want 0 0", rd[2:0], ecore_resetn);
        else passed++;
    endtask

    task automatic test_doorbell();
        logic [31:0] rd;
        logic er, rv;
        int lows, highs;
        boot_to_run(lows);
        total++;
        if (ecore_irq !== 1'b0) $display("FAIL db_idle_level: got %b want 0", ecore_irq);
        else passed++;
        bus(1'b1, 8'h10, 32'hDEAD, rd, er, rv);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            if (ecore_irq) highs++;
            @(negedge clk);
        end
        total++;
        if (highs !== 4) $display("FAIL db_pulse_run: got %0d want 4", highs);
        else passed++;
        bus(1'b1, 8'h00, 32'h2, rd, er, rv);
        bus(1'b1, 8'h10, 32'h1, rd, er, rv);
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            if (ecore_irq) highs++;
            @(negedge clk);
        end
        total++;
        if (highs !== 0) $display("FAIL db_pulse_idle: got %0d want 0", highs);
        else passed++;
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        logic er, rv;
        int lows;
        bus(1'b0, 8'h20, 32'h0, rd, er, rv);
        total++;
        if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0)
            $display("FAIL unmapped_read: got rv=%b err=%b rd=%h want 1 1 0", rv, er, rd);
        else passed++;
        @(negedge clk);
        total++;
        if (reg_rvalid !== 1'b0) $display("FAIL rvalid_single: got %b want 0", reg_rvalid);
        else passed++;
        bus(1'b1, 8'h0C, 32'h7, rd, er, rv);
`ifdef HT_ECORE_WDOG_EN
        bus(1'b1, 8'h14, 32'd50, rd, er, rv);
        total++;
        if (er !== 1'b0) $display("FAIL wdog_mapped: got err=%b want 0", er);
        else passed++;
        boot_to_run(lows);
        repeat (60) @(negedge clk);
        bus(1'b0, 8'h04, 32'h0, rd, er, rv);
        total++;
        if (rd[2:0] !== 3'd4) $display("FAIL wdog_state: got %0d want 4", rd[2:0]);
        else passed++;
        bus(1'b0, 8'h08, 32'h0, rd, er, rv);
        total++;
        if (rd !== 32'd50) $display("FAIL wdog_cycles: got %0d want 50", rd);
        else passed++;
        bus(1'b0, 8'h0C, 32'h0, rd, er, rv);
        total++;
        if (rd !== 32'h4) $display("FAIL wdog_irq_stat: got %h want 4", rd);
        else passed++;
        bus(1'b1, 8'h00, 32'h2, rd, er, rv);
`else
        bus(1'b0, 8'h14, 32'h0, rd, er, rv);
        total++;
        if (er !== 1'b1 || rd !== 32'h0)
            $display("FAIL wdog_unmapped: got err=%b rd=%h want 1 0", er, rd);
        else passed++;
        lows = 0;
`endif
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        logic er, rv;
        int lows;
        boot_to_run(lows);
        repeat (10) @(negedge clk);
        bus(1'b1, 8'h10, 32'h1, rd, er, rv);
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if ({ecore_resetn, ecore_irq, pcore_irq, reg_rvalid, reg_err} !== 5'b0 ||
            reg_rdata !== 32'h0)
            $display("FAIL async_reset: got %b/%h want 00000/0",
                     {ecore_resetn, ecore_irq, pcore_irq, reg_rvalid, reg_err}, reg_rdata);
        else passed++;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        bus(1'b0, 8'h04, 32'h0, rd, er, rv);
        total++;
        if (rd[2:0] !== 3'd0) $display("FAIL reset_state: got %0d want 0", rd[2:0]);
        else passed++;
        bus(1'b0, 8'h08, 32'h0, rd, er, rv);
        total++;
        if (rd !== 32'h0) $display("FAIL reset_cycles: got %0d want 0", rd);
        else passed++;
    endtask

    initial begin
        rst_ni    = 1'b0;
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        halted    = 1'b0;
        fault     = 1'b0;
        wfi       = 1'b0;
        test_reset();
        test_boot();
        test_run_done();
        test_fault_priority();
        test_doorbell();
        test_decode();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
